seg_scan_bcd: RTL and testbench
===============================

// Module: seg_scan_bcd
// PURPOSE
//   Parametrised multiplexed 7-segment driver with a built-in sequential binary-to-BCD converter.
//   - Accepts a binary value on a load strobe and converts it to NUM_DIG BCD digits by shift-add-3.
//   - Scans the digits one at a time onto a common segment bus.
//   - Supports per-digit decimal point, per-digit blink, leading-zero blanking and overflow indication.
//   - Sits between the measurement/control logic and the board's display pins.
// PARAMETERS
//   NUM_DIG      5       number of digits; digit 0 = least significant
//   BIN_W        16      width of the binary input value
//   SCAN_DIV     50000   sys_clk cycles per digit slot (scan tick period)
//   BLINK_DIV    250     scan ticks per blink half-period
//   SEL_ACT_LOW  1       1: seg_sel active-low; 0: active-high
//   SEG_ACT_LOW  1       1: seg_led active-low; 0: active-high
// PORTS
//   sys_clk     in   1        system clock
//   sys_rst     in   1        asynchronous reset, active-high
//   bin_val     in   BIN_W    value to display; sampled when val_load=1
//   val_load    in   1        single-cycle load strobe
//   dp_mask     in   NUM_DIG  decimal point enable per digit; live, not latched
//   blink_mask  in   NUM_DIG  blink enable per digit; live, not latched
//   blank_lz    in   1        1: blank leading zeros (digit 0 is never blanked)
//   busy        out  1        conversion in progress
//   ovf         out  1        last converted value > 10^NUM_DIG-1
//   seg_sel     out  NUM_DIG  one-hot digit select
//   seg_led     out  8        segments {dp,g,f,e,d,c,b,a}
// BEHAVIOUR
//   Reset (async, immediate):
//     - Conversion FSM goes to IDLE; pending slot is cleared.
//     - Display register = all zeros; ovf=0; busy=0.
//     - Scan counter=0; digit index=0; blink phase=0.
//     - seg_sel = all digits inactive; seg_led = all segments off.
//   Conversion FSM:
//     - States:
//         IDLE  -> LOAD on val_load or pending
//         LOAD  -> SHIFT
//         SHIFT -> DONE after exactly BIN_W shift cycles
//         DONE  -> IDLE, or -> LOAD if pending is set
//     - Each SHIFT cycle: add 3 to every BCD nibble >=5, then shift {bcd,bin} left by 1.
//     - BCD register width is 4*NUM_DIG+4; the extra top nibble detects overflow.
//     - DONE: display register <= low NUM_DIG nibbles; ovf <= (top nibble != 0).
//     - Latency: val_load sampled at edge T.
//         - busy=1 from T+1.
//         - Display register and ovf update, and busy=0, at edge T+BIN_W+2.
//     - val_load while busy: bin_val is stored in a one-deep pending slot.
//         - A later load overwrites the pending slot (newest wins).
//         - The pending value is converted immediately after DONE; busy stays 1 throughout.
//     - val_load in the same cycle as DONE counts as pending.
//   Scan:
//     - Counter runs 0..SCAN_DIV-1; terminal count = scan tick.
//     - On a tick the index advances: 0..NUM_DIG-1, then wraps to 0.
//     - seg_sel and seg_led are registered from the same next index on the same edge (no one-slot skew).
//     - The first tick after reset selects digit 0.
//   Blink:
//     - A counter of scan ticks toggles the blink phase every BLINK_DIV ticks.
//     - While phase=1, digits with blink_mask set show all segments off, including dp.
//   Digit content, highest priority first:
//     - blink-off -> blank
//     - ovf=1 -> '-' (g only; dp per dp_mask)
//     - leading zero with blank_lz -> blank (dp per dp_mask)
//     - else BCD glyph
//   Leading zero: digit i>0 whose nibble and all higher nibbles are 0.
//   Glyphs (active-high 7 bits): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F '-'=40 blank=00.
//     - dp adds bit 7.
//     - Apply output polarity only at the outputs (SEG_ACT_LOW, SEL_ACT_LOW).
//   Display register changes are picked up at the next scan tick.
// TESTING (SCAN_DIV=4, BLINK_DIV=2, default polarity unless noted)
//   1. Assert sys_rst mid-cycle -> same cycle:
//        seg_sel=5'b11111, seg_led=8'hFF, busy=0, ovf=0.
//   2. bin_val=1234, val_load, blank_lz=1:
//        - busy high for 17 cycles.
//        - Scan shows digits 0..4 = 8'h99 (4), 8'hB0 (3), 8'hA4 (2), 8'hF9 (1), 8'hFF (blank).
//   3. NUM_DIG=4, bin_val=65535 -> ovf=1; every digit shows 8'hBF ('-').
//   4. Loads of 10, 20, 30 on consecutive cycles:
//        - 10 converts first, then 30; 20 is never displayed.
//        - busy stays high continuously until 30 is latched.
//   5. blink_mask=5'b00001, bin_val=7, dp_mask=5'b00001:
//        - Digit 0 alternates 8'h78 / 8'hFF every 2 scan ticks.
//        - Other digits are unaffected.
//   6. Pulse sys_rst during SHIFT after a load of 999:
//        - busy=0, display all zeros, no late update of the display register.

Source files
------------

// File: rtl/seg_scan_bcd.sv
// Multiplexed 7-segment driver with a sequential shift-add-3 binary-to-BCD converter.
// Conversion FSM fills a display register; an independent scan/blink engine drives the pins.
module seg_scan_bcd #(
  parameter int unsigned NUM_DIG     = 5,
  parameter int unsigned BIN_W       = 16,
  parameter int unsigned SCAN_DIV    = 50000,
  parameter int unsigned BLINK_DIV   = 250,
  parameter bit          SEL_ACT_LOW = 1'b1,
  parameter bit          SEG_ACT_LOW = 1'b1
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [BIN_W-1:0]   bin_val,
  input  logic               val_load,
  input  logic [NUM_DIG-1:0] dp_mask,
  input  logic [NUM_DIG-1:0] blink_mask,
  input  logic               blank_lz,
  output logic               busy,
  output logic               ovf,
  output logic [NUM_DIG-1:0] seg_sel,
  output logic [7:0]         seg_led
);

  localparam int unsigned BCD_W  = 4 * NUM_DIG + 4;
  localparam int unsigned SR_W   = BCD_W + BIN_W;
  localparam int unsigned CNT_W  = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BLK_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned IDX_W  = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;

  localparam logic [NUM_DIG-1:0] SEL_OFF = SEL_ACT_LOW ? '1 : '0;
  localparam logic [7:0]         SEG_OFF = SEG_ACT_LOW ? 8'hFF : 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state;
  logic [BIN_W-1:0]     cur_val;
  logic [BIN_W-1:0]     pend_val;
  logic                 pend;
  logic [SR_W-1:0]      sr;
  logic [SR_W-1:0]      sr_adj;
  logic [CNT_W-1:0]     sh_cnt;
  logic                 ovf_st;
  logic [4*NUM_DIG-1:0] disp;

  logic [SCAN_W-1:0]    scan_cnt;
  logic [IDX_W-1:0]     idx;
  logic [BLK_W-1:0]     blk_cnt;
  logic                 phase;
  logic                 tick;
  logic [3:0]           nib;
  logic                 lz;
  logic                 dp;
  logic [7:0]           seg_on;
  logic [NUM_DIG-1:0]   sel_on;

  // Add-3 correction on every BCD nibble (including the overflow nibble) before the shift
  always_comb begin
    sr_adj = sr;
    for (int i = 0; i <= int'(NUM_DIG); i++) begin
      if (sr[BIN_W + 4*i +: 4] >= 4'd5)
        sr_adj[BIN_W + 4*i +: 4] = sr[BIN_W + 4*i +: 4] + 4'd3;
    end
  end

  // Conversion FSM; a load arriving while not idle lands in the one-deep pending slot
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state    <= IDLE;
      cur_val  <= '0;
      pend_val <= '0;
      pend     <= 1'b0;
      sr       <= '0;
      sh_cnt   <= '0;
      ovf_st   <= 1'b0;
      disp     <= '0;
      ovf      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (val_load) begin
            cur_val <= bin_val;
            state   <= LOAD;
          end else if (pend) begin
            cur_val <= pend_val;
            pend    <= 1'b0;
            state   <= LOAD;
          end
        end
        LOAD: begin
          busy   <= 1'b1;
          sr     <= {{BCD_W{1'b0}}, cur_val};
          sh_cnt <= '0;
          ovf_st <= 1'b0;
          state  <= SHIFT;
          if (val_load) begin
            pend     <= 1'b1;
            pend_val <= bin_val;
          end
        end
        SHIFT: begin
          sr     <= {sr_adj[SR_W-2:0], 1'b0};
          ovf_st <= ovf_st | sr_adj[SR_W-1];
          sh_cnt <= sh_cnt + 1'b1;
          if (sh_cnt == CNT_W'(BIN_W - 1))
            state <= DONE;
          if (val_load) begin
            pend     <= 1'b1;
            pend_val <= bin_val;
          end
        end
        DONE: begin
          disp <= sr[BIN_W +: 4*NUM_DIG];
          ovf  <= (sr[SR_W-1 -: 4] != 4'd0) | ovf_st;
          if (pend) begin
            cur_val <= pend_val;
            pend    <= val_load;
            if (val_load)
              pend_val <= bin_val;
            state <= LOAD;
          end else if (val_load) begin
            cur_val <= bin_val;
            state   <= LOAD;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign tick = (scan_cnt == SCAN_W'(SCAN_DIV - 1));

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'h3F;
      4'd1:    glyph = 7'h06;
      4'd2:    glyph = 7'h5B;
      4'd3:    glyph = 7'h4F;
      4'd4:    glyph = 7'h66;
      4'd5:    glyph = 7'h6D;
      4'd6:    glyph = 7'h7D;
      4'd7:    glyph = 7'h07;
      4'd8:    glyph = 7'h7F;
      4'd9:    glyph = 7'h6F;
      default: glyph = 7'h00;
    endcase
  endfunction

  // Content of the digit about to be selected, in active-high form
  always_comb begin
    nib    = disp[4*32'(idx) +: 4];
    lz     = (idx != '0) && ((disp >> (32'd4 * 32'(idx))) == '0);
    dp     = dp_mask[idx];
    sel_on = NUM_DIG'(1) << idx;
    seg_on = {dp, glyph(nib)};
    if (phase && blink_mask[idx])
      seg_on = 8'h00;
    else if (ovf)
      seg_on = {dp, 7'h40};
    else if (blank_lz && lz)
      seg_on = {dp, 7'h00};
  end

  // Scan and blink timing; outputs are refreshed only on a scan tick
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      scan_cnt <= '0;
      idx      <= '0;
      blk_cnt  <= '0;
      phase    <= 1'b0;
      seg_sel  <= SEL_OFF;
      seg_led  <= SEG_OFF;
    end else if (tick) begin
      scan_cnt <= '0;
      seg_sel  <= sel_on ^ SEL_OFF;
      seg_led  <= seg_on ^ SEG_OFF;
      idx      <= (idx == IDX_W'(NUM_DIG - 1)) ? '0 : idx + 1'b1;
      if (blk_cnt == BLK_W'(BLINK_DIV - 1)) begin
        blk_cnt <= '0;
        phase   <= ~phase;
      end else begin
        blk_cnt <= blk_cnt + 1'b1;
      end
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_scan_bcd.sv
// Bench for seg_scan_bcd: 5-digit and 4-digit instances share stimulus and are checked
// every cycle against an arithmetic model of conversion timing, scan order and glyphs.
module tb_seg_scan_bcd;

  localparam int BIN_W = 16;
  localparam int LAT   = BIN_W + 2;
  localparam logic [6:0] GL [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                     7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic             sys_clk = 1'b0;
  logic             sys_rst = 1'b0;
  logic [BIN_W-1:0] bin_val = '0;
  logic             val_load = 1'b0;
  logic [4:0]       dp_mask = '0;
  logic [4:0]       blink_mask = '0;
  logic             blank_lz = 1'b0;

  logic       busy5, ovf5, busy4, ovf4;
  logic [4:0] sel5;
  logic [3:0] sel4;
  logic [7:0] led5, led4;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 sys_clk = ~sys_clk;

  seg_scan_bcd #(.NUM_DIG(5), .BIN_W(BIN_W), .SCAN_DIV(4), .BLINK_DIV(2),
                 .SEL_ACT_LOW(1'b1), .SEG_ACT_LOW(1'b1)) dut5 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .bin_val(bin_val), .val_load(val_load),
    .dp_mask(dp_mask), .blink_mask(blink_mask), .blank_lz(blank_lz),
    .busy(busy5), .ovf(ovf5), .seg_sel(sel5), .seg_led(led5));

  seg_scan_bcd #(.NUM_DIG(4), .BIN_W(BIN_W), .SCAN_DIV(4), .BLINK_DIV(2),
                 .SEL_ACT_LOW(1'b1), .SEG_ACT_LOW(1'b1)) dut4 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .bin_val(bin_val), .val_load(val_load),
    .dp_mask(dp_mask[3:0]), .blink_mask(blink_mask[3:0]), .blank_lz(blank_lz),
    .busy(busy4), .ovf(ovf4), .seg_sel(sel4), .seg_led(led4));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int p10(input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r *= 10;
    return r;
  endfunction

  // Pin-level (active-low) pattern for digit d of a displayed decimal value
  function automatic logic [7:0] exp_led(input int dv, input bit ov, input int d, input bit ph,
                                         input logic [4:0] dpm, input logic [4:0] bm,
                                         input bit blz);
    logic [7:0] g;
    int dig;
    bit lzero;
    dig   = (dv / p10(d)) % 10;
    lzero = (d > 0) && (dv / p10(d) == 0);
    if (ph && bm[d])       g = 8'h00;
    else if (ov)           g = {dpm[d], 7'h40};
    else if (blz && lzero) g = {dpm[d], 7'h00};
    else                   g = {dpm[d], GL[dig]};
    return ~g;
  endfunction

  // Behavioural model: [0] = 5-digit instance, [1] = 4-digit instance
  int         n_edge;
  bit         act[2], pnd[2], busy_e[2], ovf_e[2];
  int         cur[2], pval[2], start_c[2], end_c[2], disp_v[2];
  logic [7:0] led_e[2];
  logic [4:0] sel_e[2];

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      n_edge = 0;
      for (int m = 0; m < 2; m++) begin
        act[m] = 0; pnd[m] = 0; busy_e[m] = 0; ovf_e[m] = 0;
        cur[m] = 0; pval[m] = 0; start_c[m] = 0; end_c[m] = 0; disp_v[m] = 0;
        led_e[m] = 8'hFF; sel_e[m] = 5'h1F;
      end
    end else begin
      n_edge++;
      for (int m = 0; m < 2; m++) begin
        int nd, k, d;
        nd = (m == 0) ? 5 : 4;
        if (n_edge % 4 == 0) begin
          k = n_edge / 4 - 1;
          d = k % nd;
          led_e[m] = exp_led(disp_v[m], ovf_e[m], d, ((k / 2) % 2) == 1,
                             dp_mask, blink_mask, blank_lz);
          sel_e[m] = ~(5'(1) << d);
        end
        if (act[m] && n_edge == end_c[m]) begin
          disp_v[m] = cur[m] % p10(nd);
          ovf_e[m]  = cur[m] > p10(nd) - 1;
          if (pnd[m]) begin
            cur[m]  = pval[m];
            pnd[m]  = val_load;
            pval[m] = int'(bin_val);
            end_c[m] = n_edge + LAT;
          end else if (val_load) begin
            cur[m]   = int'(bin_val);
            end_c[m] = n_edge + LAT;
          end else begin
            act[m]    = 0;
            busy_e[m] = 0;
          end
        end else if (val_load) begin
          if (!act[m]) begin
            act[m]     = 1;
            cur[m]     = int'(bin_val);
            start_c[m] = n_edge;
            end_c[m]   = n_edge + LAT;
          end else begin
            pnd[m]  = 1;
            pval[m] = int'(bin_val);
          end
        end
        if (act[m] && n_edge == start_c[m] + 1) busy_e[m] = 1;
      end
    end
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge sys_clk) begin
    if (chk_en) begin
      check("busy5", 32'(busy5), 32'(busy_e[0]));
      check("ovf5",  32'(ovf5),  32'(ovf_e[0]));
      check("sel5",  32'(sel5),  32'(sel_e[0]));
      check("led5",  32'(led5),  32'(led_e[0]));
      check("busy4", 32'(busy4), 32'(busy_e[1]));
      check("ovf4",  32'(ovf4),  32'(ovf_e[1]));
      check("sel4",  32'(sel4),  32'(sel_e[1][3:0]));
      check("led4",  32'(led4),  32'(led_e[1]));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic load(input int v);
    bin_val  = BIN_W'(v);
    val_load = 1'b1;
    @(negedge sys_clk);
    val_load = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    cyc(2);
    while ((busy5 || busy4) && t < 200) begin
      @(negedge sys_clk);
      t++;
    end
    if (t >= 200) check("wait_idle_timeout", 0, 1);
  endtask

  task automatic wait_sel(input int d);
    logic [4:0] want;
    int t = 0;
    want = ~(5'(1) << d);
    while (sel5 !== want && t < 100) begin
      @(negedge sys_clk);
      t++;
    end
    if (t >= 100) check("wait_sel_timeout", 0, 1);
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge sys_clk);
      if (busy5) cnt++;
      else if (cnt > 0) break;
    end
  endtask

  initial begin
    logic [7:0] exp2 [5];
    int cnt, n78, nff;
    exp2 = '{8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hFF};

    #2 sys_rst = 1'b1;
    chk_en = 1'b1;
    cyc(2);
    sys_rst = 1'b0;

    // 1234 with leading-zero blanking
    blank_lz = 1'b1;
    load(1234);
    count_busy(cnt);
    check("busy_len_1234", 32'(cnt), 32'd17);
    cyc(24);
    for (int d = 0; d < 5; d++) begin
      wait_sel(d);
      check($sformatf("glyph_1234_d%0d", d), 32'(led5), 32'(exp2[d]));
    end

    // asynchronous reset mid-cycle while converting
    load(4321);
    cyc(6);
    check("busy_before_rst", 32'(busy5), 32'd1);
    @(posedge sys_clk);
    #3 sys_rst = 1'b1;
    #1;
    check("rst_sel5", 32'(sel5), 32'h1F);
    check("rst_led5", 32'(led5), 32'hFF);
    check("rst_busy5", 32'(busy5), 32'd0);
    check("rst_ovf5", 32'(ovf5), 32'd0);
    check("rst_sel4", 32'(sel4), 32'hF);
    @(negedge sys_clk);
    sys_rst = 1'b0;

    // overflow on the 4-digit instance only
    load(65535);
    wait_idle();
    cyc(24);
    check("ovf4_65535", 32'(ovf4), 32'd1);
    check("ovf5_65535", 32'(ovf5), 32'd0);
    for (int j = 0; j < 4; j++) begin
      check("dash4", 32'(led4), 32'hBF);
      cyc(4);
    end

    // back-to-back loads: newest pending wins, busy continuous
    load(10);
    load(20);
    load(30);
    check("busy_chain_start", 32'(busy5), 32'd1);
    count_busy(cnt);
    check("busy_chain_len", 32'(cnt), 32'(2 * LAT - 3));
    cyc(24);
    wait_sel(1);
    check("chain_d1_is_3", 32'(led5), 32'hB0);
    wait_sel(0);
    check("chain_d0_is_0", 32'(led5), 32'hC0);

    // blink with decimal point on digit 0
    blink_mask = 5'b00001;
    dp_mask    = 5'b00001;
    load(7);
    wait_idle();
    cyc(24);
    n78 = 0;
    nff = 0;
    for (int j = 0; j < 4; j++) begin
      wait_sel(0);
      if (led5 == 8'h78) n78++;
      else if (led5 == 8'hFF) nff++;
      cyc(1);
    end
    check("blink_on_seen", 32'(n78 > 0), 32'd1);
    check("blink_off_seen", 32'(nff > 0), 32'd1);
    check("blink_other", 32'(4 - n78 - nff), 32'd0);
    blink_mask = '0;
    dp_mask    = '0;

    // reset during SHIFT must not leak a late display update
    load(999);
    cyc(8);
    check("busy_in_shift", 32'(busy5), 32'd1);
    @(posedge sys_clk);
    #2 sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    cyc(40);
    check("busy_after_rst", 32'(busy5), 32'd0);
    wait_sel(0);
    check("rst_d0_zero", 32'(led5), 32'hC0);
    wait_sel(2);
    check("rst_d2_blank", 32'(led5), 32'hFF);

    // randomized traffic checked by the model
    for (int c = 0; c < 2500; c++) begin
      val_load = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 7))
        0:       bin_val = 16'd0;
        1:       bin_val = 16'd9999;
        2:       bin_val = 16'd10000;
        3:       bin_val = 16'hFFFF;
        default: bin_val = 16'($urandom);
      endcase
      if ($urandom_range(0, 49) == 0) begin
        dp_mask    = 5'($urandom);
        blink_mask = 5'($urandom);
        blank_lz   = 1'($urandom);
      end
      @(negedge sys_clk);
    end
    val_load = 1'b0;
    wait_idle();
    cyc(30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
